// File: rtl/riscv_muldiv_pkg.sv
// Shared encodings and operand-signedness helpers for the iterative RV32M multiply/divide unit.
package riscv_muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] FNC_MUL    = 3'b000;
    localparam logic [2:0] FNC_MULH   = 3'b001;
    localparam logic [2:0] FNC_MULHSU = 3'b010;
    localparam logic [2:0] FNC_MULHU  = 3'b011;
    localparam logic [2:0] FNC_DIV    = 3'b100;
    localparam logic [2:0] FNC_DIVU   = 3'b101;
    localparam logic [2:0] FNC_REM    = 3'b110;
    localparam logic [2:0] FNC_REMU   = 3'b111;

    function automatic logic a_is_signed(input logic [2:0] op);
        case (op)
            FNC_MUL, FNC_MULH, FNC_MULHSU, FNC_DIV, FNC_REM: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        case (op)
            FNC_MUL, FNC_MULH, FNC_DIV, FNC_REM: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Remainder follows the dividend; products and quotients follow the sign difference.
    function automatic logic result_neg(input logic [2:0] op, input logic sa, input logic sb);
        case (op)
            FNC_MUL, FNC_MULH, FNC_DIV: return sa ^ sb;
            FNC_MULHSU, FNC_REM:        return sa;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_muldiv_sign.sv
// Conditional two's-complement negate, used both for operand magnitudes and result fixup.
module riscv_muldiv_sign #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             negate,
    output logic [WIDTH-1:0] data_out
);

    assign data_out = negate ? ((~data_in) + {{(WIDTH-1){1'b0}}, 1'b1}) : data_in;

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide: one bit per cycle on magnitudes, sign fixup at the end.
module riscv_muldiv
    import riscv_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             stall,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_r, next_state_s;
    logic                 busy_r, done_r;
    logic [2:0]           op_r;
    logic                 neg_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     mag_r, result_r;
    logic [2*WIDTH-1:0]   acc_r, acc_next_s;
    logic [WIDTH-1:0]     abs_a_s, abs_b_s;
    logic                 special_s;
    logic [WIDTH-1:0]     special_val_s;
    logic [WIDTH:0]       mul_sum_s, div_shift_s, div_diff_s;
    logic [2*WIDTH-1:0]   fix_in_s, fix_out_s;
    logic [WIDTH-1:0]     final_s;

    riscv_muldiv_sign #(.WIDTH(WIDTH)) u_abs_a (
        .data_in (a),
        .negate  (a[WIDTH-1] & a_is_signed(op)),
        .data_out(abs_a_s)
    );

    riscv_muldiv_sign #(.WIDTH(WIDTH)) u_abs_b (
        .data_in (b),
        .negate  (b[WIDTH-1] & b_is_signed(op)),
        .data_out(abs_b_s)
    );

    riscv_muldiv_sign #(.WIDTH(2*WIDTH)) u_fix (
        .data_in (fix_in_s),
        .negate  (neg_r),
        .data_out(fix_out_s)
    );

    // Divide-by-zero and signed overflow are resolved at accept without iterating.
    always_comb begin
        special_s     = 1'b0;
        special_val_s = ZERO;
        if (op[2] && (b == ZERO)) begin
            special_s     = 1'b1;
            special_val_s = op[1] ? a : ONES;
        end else if (op[2] && !op[0] && (a == MIN_VAL) && (b == ONES)) begin
            special_s     = 1'b1;
            special_val_s = op[1] ? ZERO : MIN_VAL;
        end else begin
            special_s     = 1'b0;
            special_val_s = ZERO;
        end
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, mag_r} : {1'b0, ZERO});
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, mag_r};
        acc_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
        if (op_r[2]) begin
            if (!div_diff_s[WIDTH]) begin
                acc_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Full-width negation of the product keeps the high half correct for MULH*.
    always_comb begin
        fix_in_s = acc_r;
        final_s  = fix_out_s[WIDTH-1:0];
        if (op_r[2]) begin
            fix_in_s = {ZERO, (op_r[1] ? acc_r[2*WIDTH-1:WIDTH] : acc_r[WIDTH-1:0])};
        end else begin
            fix_in_s = acc_r;
        end
        case (op_r)
            FNC_MULH, FNC_MULHSU, FNC_MULHU: final_s = fix_out_s[2*WIDTH-1:WIDTH];
            default:                         final_s = fix_out_s[WIDTH-1:0];
        endcase
    end

    // Next-state logic: kill beats stall, stall beats everything else.
    always_comb begin
        next_state_s = state_r;
        if (kill) begin
            next_state_s = ST_IDLE;
        end else if (stall) begin
            next_state_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: next_state_s = start ? (special_s ? ST_DONE : ST_CALC) : ST_IDLE;
                ST_CALC: next_state_s = (cnt_r == LAST_CNT) ? ST_SIGN : ST_CALC;
                ST_SIGN: next_state_s = ST_DONE;
                ST_DONE: next_state_s = ST_IDLE;
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // State register with registered busy/done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Datapath registers; frozen by stall and left untouched by kill.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= 3'b000;
            neg_r    <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            mag_r    <= ZERO;
            acc_r    <= {2*WIDTH{1'b0}};
            result_r <= ZERO;
        end else if (!kill && !stall) begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        neg_r <= result_neg(op, a[WIDTH-1], b[WIDTH-1]);
                        cnt_r <= {CNT_W{1'b0}};
                        mag_r <= op[2] ? abs_b_s : abs_a_s;
                        acc_r <= {ZERO, (op[2] ? abs_a_s : abs_b_s)};
                        if (special_s) begin
                            result_r <= special_val_s;
                        end
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    acc_r <= acc_next_s;
                end
                ST_SIGN: result_r <= final_s;
                default: ;
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv: directed cases plus randomized operations vs an arithmetic model.
module tb_riscv_muldiv;
    import riscv_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, stall, kill;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int total  = 0;
    int passed = 0;

    logic [2:0]  r_op;
    logic [31:0] r_a, r_b, prev;
    int          n, width_cnt;

    riscv_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .stall(stall), .kill(kill), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      ux = longint'({32'd0, x});
        longint      uy = longint'({32'd0, y});
        logic [63:0] p;
        case (o)
            FNC_MUL:    begin p = 64'(sx * sy); return p[31:0];  end
            FNC_MULH:   begin p = 64'(sx * sy); return p[63:32]; end
            FNC_MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
            FNC_MULHU:  begin p = 64'(ux * uy); return p[63:32]; end
            FNC_DIV: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = 64'(sx / sy); return p[31:0];
            end
            FNC_DIVU: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                return x / y;
            end
            FNC_REM: begin
                if (y == 32'd0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sx % sy); return p[31:0];
            end
            default: begin
                if (y == 32'd0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && y == 32'd0) return 1;
        if ((o == FNC_DIV || o == FNC_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one op, optionally poke start while busy, then check latency, result and a start-in-DONE.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int poke);
        logic [31:0] exp;
        int          cnt;
        exp = model(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        step();
        cnt = 1;
        a = $urandom(); b = $urandom();
        while (!done && cnt < 100) begin
            start = (cnt == poke);
            op    = 3'($urandom_range(0, 7));
            step();
            cnt++;
        end
        check({tag, " latency"}, 32'(cnt), 32'(latency(o, x, y)));
        check({tag, " result"}, result, exp);
        start = 1'b1; op = FNC_MUL; a = 32'd9; b = 32'd9;
        step();
        start = 1'b0;
        check({tag, " idle after done"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; kill = 1'b0;
        op = 3'd0; a = 32'd0; b = 32'd0;
        step(); step();
        check("reset state", {busy, done, 30'd0}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;
        step();

        run_op("mul", FNC_MUL, 32'hFFFF_FFFF, 32'd2, -1);
        run_op("mulh", FNC_MULH, 32'hFFFF_FFFF, 32'd2, -1);
        run_op("mulhu", FNC_MULHU, 32'hFFFF_FFFF, 32'd2, -1);
        run_op("mulhsu", FNC_MULHSU, 32'hFFFF_FFFF, 32'd2, -1);
        run_op("div", FNC_DIV, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("rem", FNC_REM, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("divu", FNC_DIVU, 32'd100, 32'd7, -1);
        run_op("remu", FNC_REMU, 32'd100, 32'd7, -1);
        run_op("divu by 0", FNC_DIVU, 32'd5, 32'd0, -1);
        run_op("rem by 0", FNC_REM, 32'd5, 32'd0, -1);
        run_op("div ovf", FNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);

        // Stall mid-CALC for 10 cycles, then across DONE for 3 cycles.
        start = 1'b1; op = FNC_MUL; a = 32'd3; b = 32'd4;
        step(); start = 1'b0; n = 1;
        repeat (4) begin step(); n++; end
        stall = 1'b1;
        repeat (10) begin step(); n++; end
        stall = 1'b0;
        while (!done && n < 100) begin step(); n++; end
        check("stall latency", 32'(n), 32'd44);
        check("stall result", result, 32'd12);
        width_cnt = 1;
        stall = 1'b1;
        repeat (3) begin step(); width_cnt += int'(done); end
        stall = 1'b0;
        step();
        width_cnt += int'(done);
        check("stalled done width", 32'(width_cnt), 32'd4);
        check("idle after stalled done", {30'd0, busy, done}, 32'd0);

        // Kill a DIV at t+5, then start a MUL at t+7.
        prev = result;
        start = 1'b1; op = FNC_DIV; a = $urandom(); b = $urandom() | 32'd1;
        step(); start = 1'b0;
        repeat (4) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        check("kill busy/done", {30'd0, busy, done}, 32'd0);
        check("kill result held", result, prev);
        step();
        run_op("mul after kill", FNC_MUL, 32'd6, 32'd7, -1);

        // Reset in the middle of CALC.
        start = 1'b1; op = FNC_DIVU; a = 32'd1000; b = 32'd3;
        step(); start = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid reset busy/done", {30'd0, busy, done}, 32'd0);
        check("mid reset result", result, 32'd0);
        step();

        run_op("start while busy", FNC_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 3);

        for (int i = 0; i < 24; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom();
            r_b  = $urandom();
            case ($urandom_range(0, 5))
                0:       r_b = 32'd0;
                1:       begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2:       r_b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, (i % 3 == 0) ? 5 : -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/riscv_muldiv.md
Name: riscv_muldiv

Overview:
- Iterative RV32M multiply/divide unit that sits in the execute (X) stage beside the ALU of the 3-stage pipeline.
- Accepts one operation from X, computes it over multiple cycles, and returns a single result.
- The controller holds the pipeline on `busy` and writes back on `done`.
- Width-parametrised so the same block serves RV32 and wider datapath experiments.

Parameters:
- WIDTH, 32, operand and result width in bits (even, ≥4)
- CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > WIDTH)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  WIDTH  rs1 operand (post-bypass)
- b  input  WIDTH  rs2 operand (post-bypass)
- stall  input  1  memory-system stall; freezes the unit
- kill  input  1  pipeline flush; aborts the current operation
- busy  output  1  high in any state other than IDLE
- done  output  1  result valid (pulse)
- result  output  WIDTH  selected result; held until the next accepted start

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (including mid-operation): state=IDLE, busy=0, done=0, result=0, counter=0.
- States: IDLE, CALC, SIGN, DONE.
- Accept: in IDLE with start=1, kill=0, stall=0:
  - latch op, sign flags, |a|, |b| (magnitudes per op signedness; MULHSU treats a signed, b unsigned);
  - go to CALC with counter=0.
- Special cases, detected at accept, go straight to DONE with result preset:
  - DIV/DIVU by 0 -> all ones.
  - REM/REMU by 0 -> a.
  - DIV with a=MIN, b=-1 -> MIN.
  - REM with a=MIN, b=-1 -> 0.
- CALC, multiply: shift-add of one bit per cycle into a 2*WIDTH accumulator.
- CALC, divide: restoring division of one bit per cycle (quotient and remainder registers).
- CALC ends when the counter reaches WIDTH-1, then goes to SIGN.
- SIGN: apply two's-complement negation.
  - Product is negated if the operand signs differ (signed ops only).
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Select result: MUL low half; MULH/MULHSU/MULHU high half; DIV(U) quotient; REM(U) remainder.
  - Go to DONE.
- DONE: done=1 for exactly one unstalled cycle, then IDLE. Result stays stable afterwards.
- Latency, start cycle t:
  - general case: done at t+WIDTH+2 (t+34 for WIDTH=32);
  - special cases: done at t+1.
- stall=1: all state, counter and datapath registers hold. If in DONE, done stays high until the cycle stall drops (the pulse is extended, not lost).
- kill=1: next state is IDLE from any state and no done is produced. kill overrides stall and start. result keeps its previous value.
- start while busy: ignored, with no effect on the in-flight operation.
- start in the same cycle as done (state=DONE): ignored; the controller must re-issue once busy=0.
- Arithmetic: all internal negation is modulo 2^WIDTH. |MIN| is represented as an unsigned WIDTH-bit value (no overflow flag).

Decomposition:
- const.vh gains `FNC_MUL`, `FNC_MULH`, `FNC_MULHSU`, `FNC_MULHU`, `FNC_DIV`, `FNC_DIVU`, `FNC_REM`, `FNC_REMU` and `MULDIV_IDLE` / `MULDIV_CALC` / `MULDIV_SIGN` / `MULDIV_DONE` state encodings.
- State and datapath registers use the existing REGISTER_R / REGISTER_R_CE primitives.
- One sub-module is natural: riscv_muldiv_sign (combinational conditional abs/negate, WIDTH-parametrised), instantiated for operand magnitudes and result fixup.

Test Plan:
- MUL, MULH, MULHU, MULHSU with a=0xFFFFFFFF, b=0x00000002:
  - MUL -> 0xFFFFFFFE; MULH -> 0xFFFFFFFF; MULHU -> 0x00000001; MULHSU -> 0xFFFFFFFF;
  - each done exactly 34 cycles after start.
- DIV with a=-7, b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF and REM a=5, b=0 -> 5, each with done 1 cycle after start. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in 1 cycle.
- Start MUL 3*4, hold stall=1 for 10 cycles mid-CALC -> result 12 at t+44. Hold stall across DONE for 3 cycles -> done high for 4 cycles, then IDLE.
- Assert kill at t+5 of a DIV:
  - busy=0 at t+6 and no done;
  - result unchanged;
  - a new MUL 6*7 started at t+7 returns 42.
- Assert reset mid-CALC -> busy=0, done=0, result=0 the next cycle. A start pulse while busy is ignored, and the original result is returned on schedule.
